// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmit path between N_REQ byte sources.
//            Grants sources round-robin, loads the granted byte into the
//            transmitter, starts the frame, waits for completion (with a
//            timeout) and inserts a guard gap before the next grant.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous reset, active-low
//            req          per-source byte-valid
//            req_data     packed bytes, source i at [i*DATA_W +: DATA_W]
//            ack          one-hot pulse: byte of the granted source taken
//            tx_data      byte to transmitter, held from load to next load
//            tx_load      pulse: transmitter loads tx_data
//            tx_start     pulse: transmitter begins frame
//            tx_busy      transmitter still shifting a frame
//            tx_done      pulse: frame complete
//            grant_id     index of current/last granted source
//            busy         high whenever the arbiter is not idle
//            err_timeout  pulse: frame did not complete in time
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           ack,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       tx_load,
   output logic                       tx_start,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       err_timeout
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int TMR_W = $clog2(TIMEOUT_CYC);
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [ID_W-1:0]  c_id_last  = ID_W'(N_REQ - 1);
   localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ARM  = 3'd2,
      S_WAIT = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t              r_state,    w_state;
   logic [ID_W-1:0]     r_rr_ptr,   w_rr_ptr;
   logic [ID_W-1:0]     r_grant_id, w_grant_id;
   logic [DATA_W-1:0]   r_tx_data,  w_tx_data;
   logic [N_REQ-1:0]    r_ack,      w_ack;
   logic                r_tx_load,  w_tx_load;
   logic                r_tx_start, w_tx_start;
   logic                r_err,      w_err;
   logic                r_busy;
   logic [TMR_W-1:0]    r_timer,    w_timer;
   logic [GAP_W-1:0]    r_gap_cnt,  w_gap_cnt;

   logic [DATA_W-1:0]   w_bytes [N_REQ];
   logic                w_found;
   logic [ID_W-1:0]     w_pick;
   logic [ID_W-1:0]     w_ptr_adv;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search starting at rr_ptr; the first requester found wins.
   always_comb begin
      logic [ID_W-1:0] idx;
      idx     = '0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
         if (!w_found && req[idx]) begin
            w_found = 1'b1;
            w_pick  = idx;
         end
      end
   end

   // Pointer moves past the source just served so it cannot win twice in a row.
   assign w_ptr_adv = (r_grant_id == c_id_last) ? '0 : r_grant_id + ID_W'(1);

   always_comb begin
      w_state    = r_state;
      w_rr_ptr   = r_rr_ptr;
      w_grant_id = r_grant_id;
      w_tx_data  = r_tx_data;
      w_timer    = r_timer;
      w_gap_cnt  = r_gap_cnt;
      w_ack      = '0;
      w_tx_load  = 1'b0;
      w_tx_start = 1'b0;
      w_err      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_id = w_pick;
               w_tx_data  = w_bytes[w_pick];
               w_ack      = N_REQ'(1) << w_pick;
               w_tx_load  = 1'b1;
               w_state    = S_LOAD;
            end
         end
         // The transmitter is already checked while the load pulse is out,
         // so an idle transmitter sees tx_start on the cycle after tx_load.
         // ARM is only occupied while the transmitter is still busy.
         S_LOAD, S_ARM: begin
            if (!tx_busy) begin
               w_tx_start = 1'b1;
               w_timer    = '0;
               w_state    = S_WAIT;
            end else begin
               w_state    = S_ARM;
            end
         end
         S_WAIT: begin
            if (tx_done || (r_timer == c_tmr_last)) begin
               w_err     = !tx_done;
               w_rr_ptr  = w_ptr_adv;
               w_gap_cnt = '0;
               w_state   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end else begin
               w_timer   = r_timer + TMR_W'(1);
            end
         end
         S_GAP: begin
            if (r_gap_cnt == c_gap_last) begin
               w_state   = S_IDLE;
            end else begin
               w_gap_cnt = r_gap_cnt + GAP_W'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_tx_data  <= '0;
         r_ack      <= '0;
         r_tx_load  <= 1'b0;
         r_tx_start <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_timer    <= '0;
         r_gap_cnt  <= '0;
      end else begin
         r_state    <= w_state;
         r_rr_ptr   <= w_rr_ptr;
         r_grant_id <= w_grant_id;
         r_tx_data  <= w_tx_data;
         r_ack      <= w_ack;
         r_tx_load  <= w_tx_load;
         r_tx_start <= w_tx_start;
         r_err      <= w_err;
         r_busy     <= (w_state != S_IDLE);
         r_timer    <= w_timer;
         r_gap_cnt  <= w_gap_cnt;
      end
   end

   assign ack         = r_ack;
   assign tx_data     = r_tx_data;
   assign tx_load     = r_tx_load;
   assign tx_start    = r_tx_start;
   assign grant_id    = r_grant_id;
   assign busy        = r_busy;
   assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter
//            (N_REQ=4, DATA_W=8, GAP_CYCLES=2, TIMEOUT_CYC=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack;
   logic [7:0]  tx_data;
   logic        tx_load;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic        tx_done = 1'b0;
   logic [1:0]  grant_id;
   logic        busy;
   logic        err_timeout;

   int n_chk = 0;
   int n_err = 0;

   uart_tx_arbiter #(
      .N_REQ       (4),
      .DATA_W      (8),
      .GAP_CYCLES  (2),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; land 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete frame: DUT is in IDLE with req set on entry and back in IDLE
   // (about to sample req) on return. tx_done arrives done_after cycles after
   // the tx_start cycle.
   task automatic serve(input int id, input logic [7:0] data, input int done_after,
                        input logic [3:0] req_after);
      tick();
      check("grant_ack",  32'(ack), 32'(1) << id);
      check("grant_load", 32'(tx_load), 32'd1);
      check("grant_id",   32'(grant_id), 32'(id));
      check("grant_data", 32'(tx_data), 32'(data));
      check("grant_start_early", 32'(tx_start), 32'd0);
      req = req_after;
      tick();
      check("start_pulse", 32'(tx_start), 32'd1);
      check("start_ack_clear", 32'({ack, tx_load}), 32'd0);
      for (int c = 0; c < done_after; c++) begin
         tick();
         check("wait_quiet", 32'({ack, tx_load, tx_start, err_timeout}), 32'd0);
         check("wait_busy", 32'(busy), 32'd1);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("gap1_busy", 32'(busy), 32'd1);
      check("gap1_no_err", 32'(err_timeout), 32'd0);
      tick();
      check("gap2_busy", 32'(busy), 32'd1);
      check("gap2_no_ack", 32'(ack), 32'd0);
      tick();
      check("back_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      // ---- 1: reset with every source requesting --------------------------
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req      = 4'hF;
      #3 rst   = 1'b0;
      tick();
      tick();
      check("rst_outputs", 32'({ack, tx_load, tx_start, busy, err_timeout}), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      rst = 1'b1;

      // ---- 3: all requesting, rotation 0,1,2,3,0 ---------------------------
      serve(0, 8'h11, 10, 4'hF);
      serve(1, 8'h22, 10, 4'hF);
      serve(2, 8'h33, 10, 4'hF);
      serve(3, 8'h44, 10, 4'hF);
      serve(0, 8'h11, 10, 4'h0);           // rr_ptr now 1

      // ---- 2: single requester 2 with 0xA5 ---------------------------------
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      serve(2, 8'hA5, 10, 4'h0);           // rr_ptr now 3

      // ---- 4: transmitter busy for 5 cycles after the load -----------------
      req = 4'b0001;
      tick();
      check("busy_ack", 32'(ack), 32'b0001);
      check("busy_load", 32'(tx_load), 32'd1);
      req     = 4'h0;
      tx_busy = 1'b1;
      for (int c = 2; c <= 6; c++) begin
         tick();
         check("armed_hold", 32'({tx_load, tx_start, ack}), 32'd0);
      end
      tick();
      tx_busy = 1'b0;
      check("armed_fall_cycle", 32'({tx_load, tx_start}), 32'd0);
      tick();
      check("armed_start", 32'(tx_start), 32'd1);
      check("armed_no_reload", 32'(tx_load), 32'd0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      tick();
      check("armed_idle", 32'(busy), 32'd0);  // rr_ptr now 1

      // ---- 5a: timeout with no tx_done -------------------------------------
      req = 4'b0010;
      tick();
      check("to_ack", 32'(ack), 32'b0010);
      req = 4'h0;
      tick();
      check("to_start", 32'(tx_start), 32'd1);
      for (int c = 1; c <= 15; c++) begin
         tick();
         check("to_no_err_yet", 32'(err_timeout), 32'd0);
      end
      tick();
      check("to_err_pulse", 32'(err_timeout), 32'd1);
      check("to_gap_busy", 32'(busy), 32'd1);
      tick();
      check("to_err_one_cycle", 32'(err_timeout), 32'd0);
      tick();
      check("to_idle", 32'(busy), 32'd0);

      // ---- 5b: pointer moved to 2 -> {0,1} requesting picks 0; done on expiry
      req = 4'b0011;
      serve(0, 8'h11, 15, 4'h0);           // rr_ptr now 1

      // ---- 6: reset during WAIT ---------------------------------------------
      req = 4'b1000;
      tick();
      check("r6_ack", 32'(ack), 32'b1000);
      req = 4'h0;
      tick();
      check("r6_start", 32'(tx_start), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("r6_async_clear", 32'({ack, tx_load, tx_start, busy, err_timeout}), 32'd0);
      check("r6_grant_clear", 32'(grant_id), 32'd0);
      check("r6_data_clear", 32'(tx_data), 32'd0);
      tick();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("r6_idle_quiet", 32'({ack, tx_load, busy, err_timeout}), 32'd0);
      end
      req = 4'b0011;                        // stale pointer 1 would pick 1
      serve(0, 8'h11, 3, 4'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
